sccb_slave: RTL and testbench



---
 rtl/sccb_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_sccb_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sccb_slave
// SCCB responder. SCL/SDA are oversampled on clk and decoded into
// ID / sub-address / data phases. 3-phase writes produce a one-cycle wr_en
// strobe. 2-phase writes only update rd_addr. A read ID (DEV_ID|1) shifts
// rd_data out MSB first on the open-drain SDA line.
//
// Optional feature: define SCCB_ACK_EN to drive ACK in the 9th bit of the
// ID, ADDR and DATA phases of a frame whose ID matches.
//
// Ports:
//   clk      in   system clock (>= 16x SCL)
//   reset_n  in   asynchronous active-low reset
//   scl      in   SCCB clock from master
//   sda_in   in   SDA as read at the pad
//   sda_oe   out  1 = pull SDA low (never driven high)
//   wr_en    out  one-cycle strobe when a 3-phase write completes
//   wr_addr  out  write register address (held after wr_en)
//   wr_data  out  write data (held after wr_en)
//   rd_addr  out  last sub-address received in a write frame
//   rd_data  in   register contents at rd_addr
//   busy     out  high between a detected START and a detected STOP
// -----------------------------------------------------------------------------
module sccb_slave #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

`ifdef SCCB_ACK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ID     = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_RD     = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
    logic                   scl_prev_r, sda_prev_r;
    logic                   scl_s, sda_s;
    logic                   scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t      state_r, state_nxt;
    logic [3:0]  cnt_r, cnt_nxt;       // 0-7 data bits, 8 = in 9th bit, 9 = 9th bit sampled
    logic [7:0]  shift_r, shift_nxt;
    logic [7:0]  byte_s;
    logic        oe_r, oe_nxt;
    logic        busy_r, busy_nxt;
    logic        wr_en_r, wr_en_nxt;
    logic [7:0]  wr_addr_r, wr_addr_nxt;
    logic [7:0]  wr_data_r, wr_data_nxt;
    logic [7:0]  rd_addr_r, rd_addr_nxt;

    // Input synchronizers plus one extra delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
            sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign byte_s     = {shift_r[6:0], sda_s};

    // FSM and datapath state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            shift_r   <= 8'd0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'd0;
            wr_data_r <= 8'd0;
            rd_addr_r <= 8'd0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            shift_r   <= shift_nxt;
            oe_r      <= oe_nxt;
            busy_r    <= busy_nxt;
            wr_en_r   <= wr_en_nxt;
            wr_addr_r <= wr_addr_nxt;
            wr_data_r <= wr_data_nxt;
            rd_addr_r <= rd_addr_nxt;
        end
    end

    // Next-state and datapath decode; bus conditions win over SCL edges
    always_comb begin
        state_nxt   = state_r;
        cnt_nxt     = cnt_r;
        shift_nxt   = shift_r;
        oe_nxt      = oe_r;
        busy_nxt    = busy_r;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_r;
        wr_data_nxt = wr_data_r;
        rd_addr_nxt = rd_addr_r;

        if (start_s) begin
            state_nxt = ST_ID;
            cnt_nxt   = 4'd0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b1;
        end else if (stop_s) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (scl_rise_s) begin
            case (state_r)
                ST_ID, ST_ADDR, ST_DATA: begin
                    if (cnt_r < 4'd8) begin
                        shift_nxt = byte_s;
                    end else begin
                        shift_nxt = shift_r;
                    end
                    if (cnt_r < 4'd9) begin
                        cnt_nxt = cnt_r + 4'd1;
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                    // Byte is complete on the LSB sample; wr_addr moves only
                    // together with wr_data so an aborted DATA phase leaves both.
                    if (cnt_r == 4'd7 && state_r == ST_ADDR) begin
                        rd_addr_nxt = byte_s;
                    end else if (cnt_r == 4'd7 && state_r == ST_DATA) begin
                        wr_en_nxt   = 1'b1;
                        wr_data_nxt = byte_s;
                        wr_addr_nxt = rd_addr_r;
                    end else begin
                        rd_addr_nxt = rd_addr_r;
                    end
                end
                ST_RD: begin
                    if (cnt_r < 4'd9) begin
                        cnt_nxt = cnt_r + 4'd1;
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                default: begin
                    cnt_nxt = cnt_r;
                end
            endcase
        end else if (scl_fall_s) begin
            // Phase transitions happen on the fall after the 9th bit so SDA
            // only ever changes while SCL is low.
            case (state_r)
                ST_ID: begin
                    if (cnt_r == 4'd8) begin
                        oe_nxt = ACK_EN & ((shift_r == DEV_ID) | (shift_r == RD_ID));
                    end else if (cnt_r == 4'd9) begin
                        cnt_nxt = 4'd0;
                        if (shift_r == DEV_ID) begin
                            state_nxt = ST_ADDR;
                            oe_nxt    = 1'b0;
                        end else if (shift_r == RD_ID) begin
                            state_nxt = ST_RD;
                            shift_nxt = rd_data;
                            oe_nxt    = ~rd_data[7];
                        end else begin
                            state_nxt = ST_IGNORE;
                            oe_nxt    = 1'b0;
                        end
                    end else begin
                        oe_nxt = 1'b0;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (cnt_r == 4'd8) begin
                        oe_nxt = ACK_EN;
                    end else if (cnt_r == 4'd9) begin
                        cnt_nxt   = 4'd0;
                        oe_nxt    = 1'b0;
                        state_nxt = (state_r == ST_ADDR) ? ST_DATA : ST_IGNORE;
                    end else begin
                        oe_nxt = 1'b0;
                    end
                end
                ST_RD: begin
                    if (cnt_r < 4'd8) begin
                        shift_nxt = {shift_r[6:0], 1'b0};
                        oe_nxt    = ~shift_r[6];
                    end else if (cnt_r == 4'd8) begin
                        oe_nxt = 1'b0;
                    end else begin
                        oe_nxt    = 1'b0;
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_IGNORE;
                    end
                end
                default: begin
                    oe_nxt = 1'b0;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    assign sda_oe  = oe_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign rd_addr = rd_addr_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_sccb_slave.sv
`timescale 1ns/1ps
module tb_sccb_slave;

`ifdef SCCB_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif
    localparam int Q = 8;   // clk cycles per quarter SCL bit

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       busy;

    logic [7:0] mem [256];

    int vectors = 0;
    int miscompares = 0;

    // reference model: frame-level expectations
    int         exp_pulses = 0;
    logic [7:0] exp_wr_addr = 8'd0;
    logic [7:0] exp_wr_data = 8'd0;
    logic [7:0] exp_rd_addr = 8'd0;

    // monitor records
    int         pulse_cnt = 0;
    int         double_cnt = 0;
    logic       wr_en_prev = 1'b0;
    logic [7:0] cap_addr = 8'd0;
    logic [7:0] cap_data = 8'd0;

    assign sda_in  = sda_m & ~sda_oe;
    assign rd_data = mem[rd_addr];

    always #5 clk = ~clk;

    sccb_slave #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl     (scl),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            cap_addr  = wr_addr;
            cap_data  = wr_data;
            if (wr_en_prev === 1'b1) double_cnt = double_cnt + 1;
        end
        wr_en_prev = wr_en;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    // one master-driven bit; checks sda_oe mid-high phase
    task automatic bit_cycle(input logic v, input logic exp_oe);
        sda_m = v; wait_q();
        scl   = 1'b1; wait_q();
        vectors++;
        if (sda_oe !== exp_oe) begin
            miscompares++;
            $display("FAIL sda_oe_bit: got %b expected %b at %0t", sda_oe, exp_oe, $time);
        end
        wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp);
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0);
        bit_cycle(1'b1, ack_exp);
    endtask

    task automatic read_byte(input logic [7:0] exp_b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl   = 1'b1; wait_q();
            vectors++;
            if (sda_in !== exp_b[i]) begin
                miscompares++;
                $display("FAIL read_bit%0d: got %b expected %b", i, sda_in, exp_b[i]);
            end
            wait_q();
            scl = 1'b0; wait_q();
        end
        bit_cycle(1'b1, 1'b0);
    endtask

    task automatic check_state(input string name);
        vectors++;
        if (pulse_cnt !== exp_pulses || wr_addr !== exp_wr_addr || wr_data !== exp_wr_data ||
            rd_addr !== exp_rd_addr || double_cnt !== 0) begin
            miscompares++;
            $display("FAIL %s: pulses=%0d/%0d wr_addr=%h/%h wr_data=%h/%h rd_addr=%h/%h double=%0d (got/expected)",
                     name, pulse_cnt, exp_pulses, wr_addr, exp_wr_addr, wr_data, exp_wr_data,
                     rd_addr, exp_rd_addr, double_cnt);
        end
        if (pulse_cnt > 0) begin
            vectors++;
            if (cap_addr !== exp_wr_addr || cap_data !== exp_wr_data) begin
                miscompares++;
                $display("FAIL %s_strobe: addr=%h/%h data=%h/%h", name, cap_addr, exp_wr_addr, cap_data, exp_wr_data);
            end
        end
    endtask

    task automatic check_busy(input logic exp_b, input string name);
        vectors++;
        if (busy !== exp_b) begin
            miscompares++;
            $display("FAIL %s: busy=%b expected %b", name, busy, exp_b);
        end
    endtask

    task automatic write3(input logic [7:0] a, input logic [7:0] d);
        bus_start();
        check_busy(1'b1, "busy_after_start");
        send_byte(8'h42, ACK_EN);
        send_byte(a, ACK_EN);
        send_byte(d, ACK_EN);
        bus_stop();
        exp_pulses++;
        exp_wr_addr = a;
        exp_wr_data = d;
        exp_rd_addr = a;
        check_busy(1'b0, "busy_after_stop");
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({sda_oe, wr_en, busy, wr_addr, wr_data, rd_addr} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_values: oe=%b en=%b busy=%b wa=%h wd=%h ra=%h",
                     sda_oe, wr_en, busy, wr_addr, wr_data, rd_addr);
        end
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_state("post_reset");
    endtask

    task automatic test_write();
        write3(8'h12, 8'h80);
        check_state("write_0x12_0x80");
        for (int k = 0; k < 5; k++) begin
            write3(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            check_state("write_random");
        end
    endtask

    task automatic test_mismatch();
        logic [7:0] id;
        for (int k = 0; k < 3; k++) begin
            id = (k == 0) ? 8'h60 : 8'($urandom_range(0, 255));
            if (id == 8'h42 || id == 8'h43) id = 8'h61;
            bus_start();
            send_byte(id, 1'b0);
            send_byte(8'($urandom_range(0, 255)), 1'b0);
            send_byte(8'h55, 1'b0);
            bus_stop();
            check_state("mismatch_id");
        end
    endtask

    task automatic test_read();
        logic [7:0] a;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 8'h0A : 8'($urandom_range(0, 255));
            if (k == 0) mem[8'h0A] = 8'hA5;
            bus_start();
            send_byte(8'h42, ACK_EN);
            send_byte(a, ACK_EN);
            bus_stop();
            exp_rd_addr = a;
            check_state("two_phase_write");
            bus_start();
            send_byte(8'h43, ACK_EN);
            read_byte(mem[a]);
            bus_stop();
            check_state("after_read");
        end
    endtask

    task automatic test_abort();
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        bus_start();
        send_byte(8'h42, ACK_EN);
        send_byte(a, ACK_EN);
        for (int i = 0; i < 4; i++) bit_cycle(1'($urandom_range(0, 1)), 1'b0);
        bus_stop();
        exp_rd_addr = a;
        check_busy(1'b0, "abort_busy");
        check_state("abort_no_write");
        write3(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        check_state("write_after_abort");
    endtask

    task automatic test_repeated_start();
        bus_start();
        send_byte(8'h42, ACK_EN);
        for (int i = 0; i < 4; i++) bit_cycle(1'($urandom_range(0, 1)), 1'b0);
        write3(8'h33, 8'h01);
        check_state("repeated_start");
    endtask

    task automatic test_reset_mid();
        bus_start();
        send_byte(8'h42, ACK_EN);
        send_byte(8'h77, ACK_EN);
        for (int i = 7; i >= 0; i--) bit_cycle(1'($urandom_range(0, 1)), 1'b0);
        exp_pulses++;
        vectors++;
        if (pulse_cnt !== exp_pulses) begin
            miscompares++;
            $display("FAIL reset_mid_pulse: got %0d expected %0d", pulse_cnt, exp_pulses);
        end
        vectors++;
        if (sda_oe !== ACK_EN) begin
            miscompares++;
            $display("FAIL data_ack: sda_oe=%b expected %b", sda_oe, ACK_EN);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({sda_oe, wr_en, busy, wr_addr, wr_data, rd_addr} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_mid: oe=%b en=%b busy=%b wa=%h wd=%h ra=%h",
                     sda_oe, wr_en, busy, wr_addr, wr_data, rd_addr);
        end
        exp_wr_addr = 8'd0;
        exp_wr_data = 8'd0;
        exp_rd_addr = 8'd0;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (6) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        write3(8'h5C, 8'hC3);
        check_state("write_after_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_abort();
        test_repeated_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
